// File: rtl/jogador_automatico_if.sv
// Player-side bus of the memory game: game outputs seen by the automatic
// player, the button drive back to the game circuit, and player status.
interface jogador_automatico_if #(
  parameter int VALOR_W = 4
);
  logic               habilitar;
  logic               modo2;
  logic [VALOR_W-1:0] leds;
  logic               vez_jogador;
  logic               ganhou;
  logic               perdeu;
  logic [VALOR_W-1:0] proximo_valor;
  logic [VALOR_W-1:0] botoes;
  logic               ocupado;
  logic [4:0]         jogadas;
  logic               erro_captura;
  logic               estouro;
  logic [3:0]         db_estado;

  modport master (
    input  habilitar, modo2, leds, vez_jogador, ganhou, perdeu, proximo_valor,
    output botoes, ocupado, jogadas, erro_captura, estouro, db_estado
  );

  modport slave (
    output habilitar, modo2, leds, vez_jogador, ganhou, perdeu, proximo_valor,
    input  botoes, ocupado, jogadas, erro_captura, estouro, db_estado
  );
endinterface

// File: rtl/jogador_automatico.sv
// Automatic memory-game player: records the leds presentation and replays it on botoes.
// Define JOGADOR_INJETA_ERRO_EN to add erro_en/erro_idx, which rotate one replayed press.
module jogador_automatico #(
  parameter int PRESS_CYCLES = 3,
  parameter int GAP_CYCLES   = 2503,
  parameter int MAX_JOGADAS  = 16,
  parameter int VALOR_W      = 4
) (
  input  logic clock,
  input  logic reset,
`ifdef JOGADOR_INJETA_ERRO_EN
  input  logic       erro_en,
  input  logic [4:0] erro_idx,
`endif
  jogador_automatico_if.master bus
);

  localparam int AW = (MAX_JOGADAS > 1) ? $clog2(MAX_JOGADAS) : 1;
  localparam int CW = $clog2((GAP_CYCLES > PRESS_CYCLES) ? GAP_CYCLES : PRESS_CYCLES) + 1;
  localparam logic [CW-1:0] PRESS_LAST = CW'(PRESS_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
  localparam logic [4:0]    MAX_J      = 5'(MAX_JOGADAS);

  typedef enum logic [3:0] {
    OCIOSO     = 4'd0,
    OBSERVA    = 4'd1,
    ESPERA_VEZ = 4'd2,
    PRESSIONA  = 4'd3,
    INTERVALO  = 4'd4,
    GRAVA      = 4'd5,
    FIM        = 4'd6
  } estado_t;

  estado_t            estado, estado_n;
  logic [VALOR_W-1:0] botoes_q, botoes_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [4:0]         wr_ptr, wr_n;
  logic [4:0]         rd_ptr, rd_n;
  logic [4:0]         jogadas_q, jogadas_n;
  logic               erro_q, erro_n;
  logic               estouro_q, estouro_n;
  logic               modo2_q, modo2_n;
  logic               grava_gap, grava_gap_n;
  logic               aguarda_vez, aguarda_n;
  logic [VALOR_W-1:0] leds_q;
  logic               leds_ativo;
  logic               vez_q, vez_qq;

  logic [VALOR_W-1:0] mem [MAX_JOGADAS];
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [VALOR_W-1:0] mem_din;

  logic [4:0]         press_idx;
  logic [VALOR_W-1:0] press_val;
  logic               captura, vez_sobe, vez_desce, aborta;

  // leds and vez_jogador come from the far end of the game, so edges are taken on registered copies
  assign captura   = (|leds_q) && !leds_ativo;
  assign vez_sobe  = vez_q && !vez_qq;
  assign vez_desce = !vez_q && vez_qq;

  always_comb begin
    press_idx = (estado == ESPERA_VEZ) ? 5'd0 : rd_ptr;
    press_val = mem[press_idx[AW-1:0]];
`ifdef JOGADOR_INJETA_ERRO_EN
    if (erro_en && (press_idx == erro_idx)) begin
      press_val = {press_val[0], press_val[VALOR_W-1:1]};
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado      <= OCIOSO;
      botoes_q    <= '0;
      cnt         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      jogadas_q   <= '0;
      erro_q      <= 1'b0;
      estouro_q   <= 1'b0;
      modo2_q     <= 1'b0;
      grava_gap   <= 1'b0;
      aguarda_vez <= 1'b0;
      leds_q      <= '0;
      leds_ativo  <= 1'b0;
      vez_q       <= 1'b0;
      vez_qq      <= 1'b0;
    end else begin
      estado      <= estado_n;
      botoes_q    <= botoes_n;
      cnt         <= cnt_n;
      wr_ptr      <= wr_n;
      rd_ptr      <= rd_n;
      jogadas_q   <= jogadas_n;
      erro_q      <= erro_n;
      estouro_q   <= estouro_n;
      modo2_q     <= modo2_n;
      grava_gap   <= grava_gap_n;
      aguarda_vez <= aguarda_n;
      leds_q      <= bus.leds;
      leds_ativo  <= |leds_q;
      vez_q       <= bus.vez_jogador;
      vez_qq      <= vez_q;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_din;
    end
  end

  always_comb begin
    estado_n    = estado;
    botoes_n    = '0;
    cnt_n       = cnt;
    wr_n        = wr_ptr;
    rd_n        = rd_ptr;
    jogadas_n   = jogadas_q;
    erro_n      = erro_q;
    estouro_n   = estouro_q;
    modo2_n     = modo2_q;
    grava_gap_n = grava_gap;
    aguarda_n   = aguarda_vez;
    mem_we      = 1'b0;
    mem_addr    = wr_ptr[AW-1:0];
    mem_din     = leds_q;
    aborta      = 1'b0;

    case (estado)
      OCIOSO: begin
        if (bus.habilitar) begin
          estado_n  = OBSERVA;
          erro_n    = 1'b0;
          estouro_n = 1'b0;
          modo2_n   = bus.modo2;
          wr_n      = '0;
          rd_n      = '0;
          jogadas_n = '0;
        end
      end

      OBSERVA: begin
        if (captura) begin
          if (wr_ptr == MAX_J) begin
            estouro_n = 1'b1;
          end else begin
            mem_we    = 1'b1;
            wr_n      = wr_ptr + 5'd1;
            jogadas_n = wr_ptr + 5'd1;
            if (!$onehot(leds_q)) begin
              erro_n = 1'b1;
            end
          end
        end
        if (vez_sobe) begin
          if (jogadas_q == 5'd0) begin
            erro_n   = 1'b1;
            estado_n = FIM;
          end else begin
            estado_n  = ESPERA_VEZ;
            aguarda_n = 1'b0;
          end
        end
      end

      // After a GRAVA round the player must see a fresh turn before replaying
      ESPERA_VEZ: begin
        if (aguarda_vez) begin
          if (vez_sobe) begin
            aguarda_n = 1'b0;
          end
        end else begin
          estado_n = PRESSIONA;
          rd_n     = '0;
          cnt_n    = '0;
          botoes_n = press_val;
        end
      end

      PRESSIONA: begin
        if (cnt == PRESS_LAST) begin
          estado_n = INTERVALO;
          cnt_n    = '0;
          rd_n     = rd_ptr + 5'd1;
        end else begin
          cnt_n    = cnt + 1'b1;
          botoes_n = botoes_q;
        end
      end

      INTERVALO: begin
        if (cnt == GAP_LAST) begin
          cnt_n = '0;
          if (rd_ptr < jogadas_q) begin
            estado_n = PRESSIONA;
            botoes_n = press_val;
          end else if (modo2_q) begin
            if (jogadas_q == MAX_J) begin
              estouro_n = 1'b1;
              estado_n  = ESPERA_VEZ;
              aguarda_n = 1'b1;
            end else begin
              mem_we      = 1'b1;
              mem_addr    = jogadas_q[AW-1:0];
              mem_din     = bus.proximo_valor;
              jogadas_n   = jogadas_q + 5'd1;
              botoes_n    = bus.proximo_valor;
              estado_n    = GRAVA;
              grava_gap_n = 1'b0;
            end
          end else begin
            estado_n = OBSERVA;
            wr_n     = '0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      GRAVA: begin
        if (!grava_gap) begin
          if (cnt == PRESS_LAST) begin
            cnt_n       = '0;
            grava_gap_n = 1'b1;
          end else begin
            cnt_n    = cnt + 1'b1;
            botoes_n = botoes_q;
          end
        end else if (cnt == GAP_LAST) begin
          cnt_n     = '0;
          estado_n  = ESPERA_VEZ;
          aguarda_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      FIM: begin
        if (!bus.habilitar) begin
          estado_n = OCIOSO;
        end
      end

      default: estado_n = OCIOSO;
    endcase

    // Aborts, lowest priority first so the later assignment wins
    if (estado != OCIOSO) begin
      if (vez_desce && ((estado == PRESSIONA) || (estado == INTERVALO))) begin
        estado_n = FIM;
        aborta   = 1'b1;
      end
      if (bus.ganhou || bus.perdeu) begin
        estado_n = FIM;
        aborta   = 1'b1;
      end
      if (!bus.habilitar) begin
        estado_n = OCIOSO;
        aborta   = 1'b1;
      end
    end

    if (aborta) begin
      botoes_n  = '0;
      mem_we    = 1'b0;
      jogadas_n = jogadas_q;
      wr_n      = wr_ptr;
    end
  end

  assign bus.botoes       = botoes_q;
  assign bus.ocupado      = (estado != OCIOSO) && (estado != FIM);
  assign bus.jogadas      = jogadas_q;
  assign bus.erro_captura = erro_q;
  assign bus.estouro      = estouro_q;
  assign bus.db_estado    = estado;

endmodule
